// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the FIR stream driver.
// Q2.6 format: WI integer bits (sign included) plus WF fraction bits.
package fir_pkg;

    localparam int WI = 2;
    localparam int WF = 6;
    localparam int WL_DEFAULT = WI + WF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2
    } fir_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock sample buffer: registered occupancy count, pointers wrap mod FIFO_DEPTH.
// The read data is the current head word, valid whenever the buffer is not empty.
module sync_fifo #(
    parameter int WL         = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [WL-1:0]                 wdata,
    input  logic                          pop,
    output logic [WL-1:0]                 rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [WL-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/fir_stream_driver.sv
// Transmit side of the FIR interface: loads the coefficient bank serially on h, then streams
// buffered samples on x, one word per cycle, flagging a sticky underrun when the buffer runs dry.
module fir_stream_driver
    import fir_pkg::*;
#(
    parameter int WL          = WL_DEFAULT,
    parameter int NTAPS       = 3,
    parameter int LOAD_CYCLES = 4,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [WL-1:0]            coef_wdata,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     s_valid,
    input  logic [WL-1:0]            s_data,
    output logic                     s_ready,
    output logic [WL-1:0]            h,
    output logic [WL-1:0]            x,
    output logic                     enable,
    output logic                     busy,
    output logic                     underrun
);

    localparam int CNT_W = $clog2(LOAD_CYCLES) + 1;
    localparam int PAD   = LOAD_CYCLES - NTAPS;
    localparam int FAW   = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT      = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [FAW:0]     FIFO_FULL_CNT = (FAW + 1)'(FIFO_DEPTH);

    fir_state_e       state_q, state_d;
    logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
    logic [WL-1:0]    coef_q [NTAPS];
    logic [WL-1:0]    h_q, h_d;
    logic [WL-1:0]    x_q, x_d;
    logic             enable_q, enable_d;
    logic             underrun_q, underrun_d;
    logic [WL-1:0]    load_word;
    logic             coef_wr;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WL-1:0]    fifo_rdata;
    logic [FAW:0]     fifo_count;

    assign fifo_push = s_valid && !fifo_full;
    assign coef_wr   = (state_q == ST_IDLE) && coef_we && (int'(coef_addr) < NTAPS);

    sync_fifo #(
        .WL         (WL),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (s_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Leading load slots are zero padding; the last NTAPS slots carry coef[0]..coef[NTAPS-1].
    always_comb begin
        load_word = '0;
        for (int i = 0; i < NTAPS; i++) begin
            if (int'(load_cnt_q) == PAD + i) begin
                load_word = coef_q[i];
            end
        end
    end

    // A stop in LOAD/STREAM suppresses that cycle's word so outputs are zero the cycle after.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        h_d        = '0;
        x_d        = '0;
        enable_d   = 1'b0;
        underrun_d = underrun_q;
        fifo_pop   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = '0;
                    underrun_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    h_d = load_word;
                    if (load_cnt_q == LAST_CNT) begin
                        state_d = ST_STREAM;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    enable_d = 1'b1;
                    if (fifo_empty) begin
                        underrun_d = 1'b1;
                    end else begin
                        fifo_pop = 1'b1;
                        x_d      = fifo_rdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            load_cnt_q <= '0;
            h_q        <= '0;
            x_q        <= '0;
            enable_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            h_q        <= h_d;
            x_q        <= x_d;
            enable_q   <= enable_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else if (coef_wr) begin
            coef_q[coef_addr] <= coef_wdata;
        end
    end

    assign s_ready  = (fifo_count != FIFO_FULL_CNT);
    assign h        = h_q;
    assign x        = x_q;
    assign enable   = enable_q;
    assign busy     = (state_q != ST_IDLE);
    assign underrun = underrun_q;

endmodule

// File: tb/tb_fir_stream_driver.sv
// Self-checking bench for fir_stream_driver: directed scenarios plus a randomized run, all
// compared against a queue-based reference model of the load-then-stream behaviour.
module tb_fir_stream_driver;

    localparam int WL    = 8;
    localparam int NTAPS = 3;
    localparam int LC    = 4;
    localparam int DEPTH = 8;
    localparam int PAD   = LC - NTAPS;

    logic          clk = 1'b0;
    logic          reset, coef_we, start, stop, s_valid;
    logic [1:0]    coef_addr;
    logic [WL-1:0] coef_wdata, s_data;
    logic          s_ready, enable, busy, underrun;
    logic [WL-1:0] h, x;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int            m_state;  // 0 idle, 1 load, 2 stream
    logic [WL-1:0] m_coef [NTAPS];
    logic [WL-1:0] m_q [$];
    logic [WL-1:0] m_hseq [$];
    logic          m_und;
    logic [WL-1:0] e_h, e_x;
    logic          e_en, e_busy, e_und, e_rdy;

    fir_stream_driver #(
        .WL          (WL),
        .NTAPS       (NTAPS),
        .LOAD_CYCLES (LC),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .start      (start),
        .stop       (stop),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .h          (h),
        .x          (x),
        .enable     (enable),
        .busy       (busy),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] obs();
        return {h, x, enable, busy, underrun, s_ready};
    endfunction

    function automatic logic [19:0] expv();
        return {e_h, e_x, e_en, e_busy, e_und, e_rdy};
    endfunction

    // Advance the model by one clock using the currently driven inputs, then clock the DUT.
    task automatic cycle();
        bit rdy_now;
        e_h  = '0;
        e_x  = '0;
        e_en = 1'b0;
        if (reset) begin
            m_state = 0;
            m_und   = 1'b0;
            m_q.delete();
            m_hseq.delete();
            foreach (m_coef[i]) m_coef[i] = '0;
        end else begin
            rdy_now = (m_q.size() < DEPTH);
            if (m_state == 0) begin
                if (coef_we && int'(coef_addr) < NTAPS) m_coef[coef_addr] = coef_wdata;
                if (start) begin
                    m_state = 1;
                    m_und   = 1'b0;
                    m_hseq.delete();
                    repeat (PAD) m_hseq.push_back('0);
                    foreach (m_coef[i]) m_hseq.push_back(m_coef[i]);
                end
            end else if (stop) begin
                m_state = 0;
            end else if (m_state == 1) begin
                e_h = m_hseq.pop_front();
                if (m_hseq.size() == 0) m_state = 2;
            end else begin
                e_en = 1'b1;
                if (m_q.size() > 0) e_x = m_q.pop_front();
                else m_und = 1'b1;
            end
            if (s_valid && rdy_now) m_q.push_back(s_data);
        end
        e_busy = (m_state != 0);
        e_und  = m_und;
        e_rdy  = (m_q.size() < DEPTH);
        @(posedge clk);
        #1;
        start   = 1'b0;
        stop    = 1'b0;
        coef_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b1; s_data = 8'hAA; start = 1'b1;
        coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = 8'h55;
        cycle();
        reset = 1'b1; s_valid = 1'b1;
        cycle();
        n_tests++;
        if (obs() !== 20'h00001) begin
            n_fail++;
            $display("FAIL reset_state got=%h want=%h", obs(), 20'h00001);
        end
        reset = 1'b0; s_valid = 1'b0;
        cycle();
        n_tests++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL reset_idle got=%h want=%h", obs(), expv());
        end
    endtask

    task automatic test_load_sequence();
        logic [WL-1:0] want [4] = '{8'h00, 8'h10, 8'h20, 8'h30};
        for (int i = 0; i < NTAPS; i++) begin
            coef_we = 1'b1; coef_addr = 2'(i); coef_wdata = 8'(8'h10 * (i + 1));
            cycle();
        end
        start = 1'b1;
        cycle();
        n_tests++;
        if (busy !== 1'b1 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL load_enter got=%h want=%h", obs(), expv());
        end
        for (int k = 0; k < LC; k++) begin
            cycle();
            n_tests++;
            if (h !== want[k] || enable !== 1'b0 || obs() !== expv()) begin
                n_fail++;
                $display("FAIL load_h slot=%0d got h=%h want h=%h (vec %h/%h)",
                         k, h, want[k], obs(), expv());
            end
        end
        cycle();
        n_tests++;
        if (enable !== 1'b1 || h !== 8'h00 || underrun !== 1'b1 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL load_to_stream got=%h want=%h", obs(), expv());
        end
        stop = 1'b1;
        cycle();
        n_tests++;
        if (busy !== 1'b0 || enable !== 1'b0 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL stream_stop got=%h want=%h", obs(), expv());
        end
    endtask

    task automatic test_preload_stream();
        s_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            s_data = 8'(i);
            cycle();
        end
        s_valid = 1'b0;
        start = 1'b1;
        cycle();
        repeat (LC) cycle();
        for (int k = 0; k < 6; k++) begin
            cycle();
            n_tests++;
            if (x !== ((k < 5) ? 8'(k + 1) : 8'h00) || underrun !== (k == 5)
                || obs() !== expv()) begin
                n_fail++;
                $display("FAIL preload_x k=%0d got x=%h und=%b want vec %h (got %h)",
                         k, x, underrun, expv(), obs());
            end
        end
        stop = 1'b1;
        cycle();
    endtask

    task automatic test_full();
        s_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            s_data = 8'($urandom);
            cycle();
        end
        n_tests++;
        if (s_ready !== 1'b0 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL full_ready got=%h want=%h", obs(), expv());
        end
        s_data = 8'hEE;
        repeat (3) cycle();
        start = 1'b1;
        s_valid = 1'b0;
        cycle();
        repeat (LC) cycle();
        for (int k = 0; k < 24; k++) begin
            s_valid = 1'($urandom);
            s_data  = 8'($urandom);
            cycle();
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL full_stream k=%0d got=%h want=%h", k, obs(), expv());
            end
        end
        s_valid = 1'b0;
        stop = 1'b1;
        cycle();
    endtask

    task automatic test_coef_during_load();
        logic [WL-1:0] want [4];
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        want[0] = 8'h00;
        want[1] = 8'($urandom_range(0, 8'h7E));
        want[2] = 8'($urandom);
        want[3] = 8'($urandom);
        for (int i = 0; i < NTAPS; i++) begin
            coef_we = 1'b1; coef_addr = 2'(i); coef_wdata = want[i + 1];
            cycle();
        end
        for (int pass = 0; pass < 2; pass++) begin
            start = 1'b1;
            cycle();
            coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = 8'h7F;
            for (int k = 0; k < LC; k++) begin
                cycle();
                n_tests++;
                if (h !== want[k] || obs() !== expv()) begin
                    n_fail++;
                    $display("FAIL coef_locked pass=%0d slot=%0d got h=%h want h=%h",
                             pass, k, h, want[k]);
                end
            end
            stop = 1'b1;
            cycle();
        end
    endtask

    task automatic test_reset_midstream();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        start = 1'b1;
        cycle();
        s_valid = 1'b1;
        for (int k = 0; k < LC; k++) begin
            s_data = 8'($urandom);
            cycle();
        end
        s_valid = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || x !== 8'h00 || s_ready !== 1'b1 || enable !== 1'b0
            || obs() !== expv()) begin
            n_fail++;
            $display("FAIL reset_midstream got=%h want=%h", obs(), expv());
        end
        start = 1'b1;
        cycle();
        repeat (LC) cycle();
        cycle();
        n_tests++;
        if (x !== 8'h00 || underrun !== 1'b1 || enable !== 1'b1 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL flushed_underrun got=%h want=%h", obs(), expv());
        end
        stop = 1'b1;
        cycle();
    endtask

    task automatic test_start_coef_same();
        logic [WL-1:0] want [4];
        want[0] = 8'h00;
        want[1] = 8'($urandom);
        want[2] = 8'($urandom);
        want[3] = 8'hC0;
        for (int i = 0; i < 2; i++) begin
            coef_we = 1'b1; coef_addr = 2'(i); coef_wdata = want[i + 1];
            cycle();
        end
        start = 1'b1; coef_we = 1'b1; coef_addr = 2'd2; coef_wdata = 8'hC0;
        cycle();
        for (int k = 0; k < LC; k++) begin
            cycle();
            n_tests++;
            if (h !== want[k] || obs() !== expv()) begin
                n_fail++;
                $display("FAIL same_cycle_coef slot=%0d got h=%h want h=%h", k, h, want[k]);
            end
        end
        stop = 1'b1;
        cycle();
        start = 1'b1;
        cycle();
        cycle();
        stop = 1'b1;
        cycle();
        n_tests++;
        if (busy !== 1'b0 || h !== 8'h00 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL stop_in_load got=%h want=%h", obs(), expv());
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            reset      = ($urandom_range(0, 99) == 0);
            start      = ($urandom_range(0, 9) == 0);
            stop       = ($urandom_range(0, 14) == 0);
            coef_we    = ($urandom_range(0, 3) == 0);
            coef_addr  = 2'($urandom);
            coef_wdata = 8'($urandom);
            s_valid    = 1'($urandom);
            s_data     = 8'($urandom);
            cycle();
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random k=%0d got=%h want=%h", k, obs(), expv());
            end
        end
        reset = 1'b0;
        s_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0;
        m_state = 0; m_und = 1'b0;
        test_reset();
        test_load_sequence();
        test_preload_stream();
        test_full();
        test_coef_during_load();
        test_reset_midstream();
        test_start_coef_same();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
